// File: rtl/ethernet_pkg.sv
// rtl/ethernet_pkg.sv - shared FSM encoding, SFD and CRC-32 constants for the ethernet receive path
package ethernet_pkg;

  typedef enum logic [1:0] {
    ST_UNDEFINED,
    ST_HUNT,
    ST_DATA,
    ST_DROP
  } state_t;

  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first serial CRC step; the register holds the bit-reversed CRC
  function automatic logic [31:0] crc_bit(input logic [31:0] crc, input logic b);
    return (crc >> 1) ^ ((crc[0] ^ b) ? reflect32(CRC_POLY) : 32'h0);
  endfunction

endpackage

// File: rtl/ethernet_rx_byte_if.sv
// rtl/ethernet_rx_byte_if.sv - PHY receive pins plus assembled byte / frame status bundle
interface ethernet_rx_byte_if #(
  parameter int PHY_W = 4,
  parameter int LEN_W = 11
);
  logic             ethernet_rx_clk;
  logic             ethernet_rx_dv;
  logic [PHY_W-1:0] ethernet_rx;
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic             frame_start;
  logic             frame_end;
  logic [LEN_W-1:0] frame_len;
  logic             align_err;
  logic             crc_ok;

  modport master (
    output ethernet_rx_clk, ethernet_rx_dv, ethernet_rx,
    input  byte_valid, rx_byte, frame_start, frame_end, frame_len, align_err, crc_ok
  );

  modport slave (
    input  ethernet_rx_clk, ethernet_rx_dv, ethernet_rx,
    output byte_valid, rx_byte, frame_start, frame_end, frame_len, align_err, crc_ok
  );
endinterface

// File: rtl/ethernet_sync.sv
// rtl/ethernet_sync.sv - multi-bit flop-chain synchroniser, cleared to zero on reset
module ethernet_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[DEPTH-1];
endmodule

// File: rtl/ethernet_rx_byte.sv
// rtl/ethernet_rx_byte.sv - MII/RMII receive deserialiser with SFD hunt and frame status
// Optional FCS check enabled by defining ETHERNET_RX_FCS_EN.
module ethernet_rx_byte
  import ethernet_pkg::*;
#(
  parameter int PHY_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  ethernet_rx_byte_if.slave bus
);
  localparam int SW = PHY_W + 2;
  localparam logic [2:0] UNIT_LAST = 3'(8 / PHY_W - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [SW-1:0]    sync_q;
  logic             s_clk, s_dv, prev_clk, rx_edge;
  logic [PHY_W-1:0] s_data;

  // clock, dv and data share one chain so they stay mutually aligned
  ethernet_sync #(.WIDTH(SW), .DEPTH(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({bus.ethernet_rx_clk, bus.ethernet_rx_dv, bus.ethernet_rx}),
    .q     (sync_q)
  );

  assign s_clk   = sync_q[SW-1];
  assign s_dv    = sync_q[PHY_W];
  assign s_data  = sync_q[PHY_W-1:0];
  assign rx_edge = s_clk & ~prev_clk;

  state_t     state;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] unit_cnt;
  logic       first_byte, hunt_sfd, crc_good;

  always_comb begin
    shreg_nxt   = {s_data, shreg[7:PHY_W]};
    bit_cnt_nxt = (bit_cnt + 4'(PHY_W) >= 4'd8) ? 4'd8 : bit_cnt + 4'(PHY_W);
    hunt_sfd    = (shreg_nxt == SFD) && (bit_cnt_nxt == 4'd8);
  end

`ifdef ETHERNET_RX_FCS_EN
  localparam logic DROP_CRC = 1'b0;
  logic [31:0] crc, crc_nxt;

  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < PHY_W; i++) crc_nxt = crc_bit(crc_nxt, s_data[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      crc <= CRC_INIT;
    else if (state == ST_HUNT && rx_edge && s_dv && hunt_sfd)
      crc <= CRC_INIT;
    else if (state == ST_DATA && rx_edge && s_dv)
      crc <= crc_nxt;
  end

  assign crc_good = (crc == reflect32(CRC_RESIDUE));
`else
  localparam logic DROP_CRC = 1'b1;
  assign crc_good = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_UNDEFINED;
      prev_clk        <= 1'b0;
      shreg           <= '0;
      bit_cnt         <= '0;
      unit_cnt        <= '0;
      first_byte      <= 1'b0;
      bus.byte_valid  <= 1'b0;
      bus.rx_byte     <= 8'h00;
      bus.frame_start <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.frame_len   <= '0;
      bus.align_err   <= 1'b0;
      bus.crc_ok      <= 1'b0;
    end else begin
      prev_clk        <= s_clk;
      bus.byte_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.frame_end   <= 1'b0;
      bus.align_err   <= 1'b0;
      bus.crc_ok      <= 1'b0;
      case (state)
        ST_UNDEFINED: begin
          bit_cnt <= '0;
          if (start) state <= ST_HUNT;
        end
        ST_HUNT: if (rx_edge) begin
          if (!s_dv) begin
            bit_cnt <= '0;
          end else if (hunt_sfd) begin
            state         <= ST_DATA;
            shreg         <= '0;
            bit_cnt       <= '0;
            unit_cnt      <= '0;
            bus.frame_len <= '0;
            first_byte    <= 1'b1;
          end else begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
          end
        end
        ST_DATA: if (rx_edge) begin
          if (s_dv) begin
            shreg <= shreg_nxt;
            if (unit_cnt == UNIT_LAST) begin
              unit_cnt        <= '0;
              bus.rx_byte     <= shreg_nxt;
              bus.byte_valid  <= 1'b1;
              bus.frame_start <= first_byte;
              first_byte      <= 1'b0;
              bus.frame_len   <= bus.frame_len + 1'b1;
              if (bus.frame_len == LEN_MAX - 1'b1) state <= ST_DROP;
            end else begin
              unit_cnt <= unit_cnt + 3'd1;
            end
          end else begin
            bus.frame_end <= 1'b1;
            bus.align_err <= (unit_cnt != 3'd0);
            bus.crc_ok    <= crc_good;
            bit_cnt       <= '0;
            state         <= ST_HUNT;
          end
        end
        ST_DROP: if (rx_edge && !s_dv) begin
          bus.frame_end <= 1'b1;
          bus.align_err <= 1'b1;
          bus.crc_ok    <= DROP_CRC;
          bit_cnt       <= '0;
          state         <= ST_HUNT;
        end
        default: state <= ST_UNDEFINED;
      endcase
    end
  end
endmodule

// File: tb/tb_ethernet_rx_byte.sv
// tb/tb_ethernet_rx_byte.sv - scoreboard bench for ethernet_rx_byte (MII and RMII instances)
module tb_ethernet_rx_byte;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

`ifdef ETHERNET_RX_FCS_EN
  localparam bit FCS = 1'b1;
`else
  localparam bit FCS = 1'b0;
`endif
  localparam logic PLAIN_CRC = !FCS;

  ethernet_rx_byte_if #(.PHY_W(4), .LEN_W(11)) if4 ();
  ethernet_rx_byte_if #(.PHY_W(2), .LEN_W(11)) if2 ();

  ethernet_rx_byte #(.PHY_W(4), .SYNC_STAGES(2), .LEN_W(11)) dut4 (
    .clk(clk), .reset(reset), .start(start), .bus(if4.slave));
  ethernet_rx_byte #(.PHY_W(2), .SYNC_STAGES(3), .LEN_W(11)) dut2 (
    .clk(clk), .reset(reset), .start(start), .bus(if2.slave));

  int vectors = 0;
  int miscompares = 0;
  int n4 = 0;
  int n2 = 0;
  logic [8:0]  exp_b4[$], exp_b2[$];
  logic [12:0] exp_e4[$], exp_e2[$];
  logic [7:0]  tx[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0]  b;
    logic [12:0] e;
    if (!reset) begin
      if (if4.byte_valid && if4.frame_end) check_val("bv_fe_overlap4", 1, 0);
      if (if4.frame_start && !if4.byte_valid) check_val("fs_alone4", 1, 0);
      if (if4.crc_ok && !if4.frame_end) check_val("crc_ok_alone4", 1, 0);
      if (if4.byte_valid) begin
        n4++;
        if (exp_b4.size() == 0) check_val("unexp_byte4", 1, 0);
        else begin
          b = exp_b4.pop_front();
          check_val("rx_byte4", 32'(if4.rx_byte), 32'(b[7:0]));
          check_val("frame_start4", 32'(if4.frame_start), 32'(b[8]));
        end
      end
      if (if4.frame_end) begin
        n4++;
        if (exp_e4.size() == 0) check_val("unexp_end4", 1, 0);
        else begin
          e = exp_e4.pop_front();
          check_val("frame_len4", 32'(if4.frame_len), 32'(e[12:2]));
          check_val("align_err4", 32'(if4.align_err), 32'(e[1]));
          check_val("crc_ok4", 32'(if4.crc_ok), 32'(e[0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0]  b;
    logic [12:0] e;
    if (!reset) begin
      if (if2.byte_valid && if2.frame_end) check_val("bv_fe_overlap2", 1, 0);
      if (if2.frame_start && !if2.byte_valid) check_val("fs_alone2", 1, 0);
      if (if2.crc_ok && !if2.frame_end) check_val("crc_ok_alone2", 1, 0);
      if (if2.byte_valid) begin
        n2++;
        if (exp_b2.size() == 0) check_val("unexp_byte2", 1, 0);
        else begin
          b = exp_b2.pop_front();
          check_val("rx_byte2", 32'(if2.rx_byte), 32'(b[7:0]));
          check_val("frame_start2", 32'(if2.frame_start), 32'(b[8]));
        end
      end
      if (if2.frame_end) begin
        n2++;
        if (exp_e2.size() == 0) check_val("unexp_end2", 1, 0);
        else begin
          e = exp_e2.pop_front();
          check_val("frame_len2", 32'(if2.frame_len), 32'(e[12:2]));
          check_val("align_err2", 32'(if2.align_err), 32'(e[1]));
          check_val("crc_ok2", 32'(if2.crc_ok), 32'(e[0]));
        end
      end
    end
  end

  // one PHY unit per rx_clk period of 8 clk; data changes while rx_clk is low
  task automatic unit4(input logic dv, input logic [3:0] d);
    @(negedge clk);
    if4.ethernet_rx_dv = dv;
    if4.ethernet_rx = d;
    if4.ethernet_rx_clk = 1'b0;
    repeat (4) @(negedge clk);
    if4.ethernet_rx_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic unit2(input logic dv, input logic [1:0] d);
    @(negedge clk);
    if2.ethernet_rx_dv = dv;
    if2.ethernet_rx = d;
    if2.ethernet_rx_clk = 1'b0;
    repeat (4) @(negedge clk);
    if2.ethernet_rx_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame4(input bit expect_out, input bit extra_nib, input logic crc_exp);
    repeat (15) unit4(1'b1, 4'h5);
    unit4(1'b1, 4'hD);
    foreach (tx[i]) begin
      if (expect_out) exp_b4.push_back({i == 0, tx[i]});
      unit4(1'b1, tx[i][3:0]);
      unit4(1'b1, tx[i][7:4]);
    end
    if (extra_nib) unit4(1'b1, 4'h9);
    if (expect_out) exp_e4.push_back({11'(tx.size()), extra_nib, crc_exp});
    repeat (2) unit4(1'b0, 4'h0);
  endtask

  task automatic frame2(input logic crc_exp);
    repeat (31) unit2(1'b1, 2'b01);
    unit2(1'b1, 2'b11);
    foreach (tx[i]) begin
      exp_b2.push_back({i == 0, tx[i]});
      for (int k = 0; k < 8; k += 2) unit2(1'b1, tx[i][k+:2]);
    end
    exp_e2.push_back({11'(tx.size()), 1'b0, crc_exp});
    repeat (2) unit2(1'b0, 2'b00);
  endtask

  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (tx[i])
      for (int k = 0; k < 8; k++)
        c = (c >> 1) ^ ((c[0] ^ tx[i][k]) ? 32'hEDB8_8320 : 32'h0);
    return ~c;
  endfunction

  initial begin
    int base;
    logic [31:0] f;
    if4.ethernet_rx_clk = 1'b0; if4.ethernet_rx_dv = 1'b0; if4.ethernet_rx = '0;
    if2.ethernet_rx_clk = 1'b0; if2.ethernet_rx_dv = 1'b0; if2.ethernet_rx = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_byte_valid", {if4.byte_valid, if2.byte_valid}, 0);
    check_val("rst_rx_byte", {if4.rx_byte, if2.rx_byte}, 0);
    check_val("rst_frame_strobes", {if4.frame_start, if4.frame_end, if2.frame_start, if2.frame_end}, 0);
    check_val("rst_frame_len4", 32'(if4.frame_len), 0);
    check_val("rst_frame_len2", 32'(if2.frame_len), 0);
    check_val("rst_flags", {if4.align_err, if4.crc_ok, if2.align_err, if2.crc_ok}, 0);

    tx = '{8'h11, 8'h22};
    base = n4;
    frame4(1'b0, 1'b0, PLAIN_CRC);
    check_val("no_strobes_start0", 32'(n4 - base), 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    tx = '{8'h01, 8'h02, 8'h03};
    frame4(1'b1, 1'b0, PLAIN_CRC);

    base = n4;
    foreach (tx[i]) begin end
    for (int k = 1; k < 12; k++) unit4(1'b1, (k == 4'hD) ? 4'h0 : 4'(k));
    repeat (2) unit4(1'b0, 4'h0);
    check_val("garbage_no_strobes", 32'(n4 - base), 0);

    for (int r = 0; r < 3; r++) begin
      tx = {};
      for (int k = 0; k < 1 + r * 2; k++) tx.push_back(8'($urandom));
      frame4(1'b1, 1'b0, PLAIN_CRC);
    end

    tx = '{8'hC3};
    frame4(1'b1, 1'b1, PLAIN_CRC);

    tx = '{8'hA5};
    frame2(PLAIN_CRC);
    tx = '{8'h3C, 8'h7E};
    frame2(PLAIN_CRC);
    check_val("queues_empty_a", exp_b4.size() + exp_e4.size() + exp_b2.size() + exp_e2.size(), 0);

    base = n4;
    repeat (15) unit4(1'b1, 4'h5);
    unit4(1'b1, 4'hD);
    unit4(1'b1, 4'h1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    unit4(1'b1, 4'h0);
    unit4(1'b1, 4'h2);
    repeat (2) unit4(1'b0, 4'h0);
    check_val("reset_mid_no_end", 32'(n4 - base), 0);
    check_val("reset_mid_len", 32'(if4.frame_len), 0);

    tx = '{8'h44};
    frame4(1'b0, 1'b0, PLAIN_CRC);
    check_val("no_strobes_after_reset", 32'(n4 - base), 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx = '{8'hDE, 8'hAD};
    frame4(1'b1, 1'b0, PLAIN_CRC);

    tx = {};
    for (int k = 0; k < 60; k++) tx.push_back(8'($urandom));
    f = fcs_of();
    for (int k = 0; k < 4; k++) tx.push_back(f[8*k+:8]);
    frame4(1'b1, 1'b0, 1'b1);
    tx[10] = tx[10] ^ 8'h08;
    frame4(1'b1, 1'b0, PLAIN_CRC);

    repeat (10) @(negedge clk);
    check_val("queues_empty_b", exp_b4.size() + exp_e4.size() + exp_b2.size() + exp_e2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ethernet_rx_byte.md
ETHERNET_RX_BYTE -- requirements
Module: ethernet_rx_byte

Interface
REQ-001 Parameter PHY_W, default 4, PHY receive data width per rx clock edge; legal values 4 (MII) and 2 (RMII-style).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth for the PHY inputs; legal values 2..4.
REQ-003 Parameter LEN_W, default 11, width of the frame byte counter.
REQ-004 clk  input  1  system clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  enable; leaves UNDEFINED after reset.
REQ-007 ethernet_rx_clk  input  1  PHY receive clock, asynchronous to clk and sampled by clk.
REQ-008 ethernet_rx_dv  input  1  PHY receive data valid.
REQ-009 ethernet_rx  input  PHY_W  PHY receive data, LSB-first within each byte.
REQ-010 byte_valid  output  1  one-cycle strobe; rx_byte is valid.
REQ-011 rx_byte  output  8  assembled payload byte; holds its value between strobes.
REQ-012 frame_start  output  1  one-cycle strobe coinciding with the first byte_valid of a frame.
REQ-013 frame_end  output  1  one-cycle strobe at end of frame.
REQ-014 frame_len  output  LEN_W  payload byte count; valid while frame_end is high.
REQ-015 align_err  output  1  valid with frame_end; frame ended with a partial byte.
REQ-016 crc_ok  output  1  valid with frame_end; FCS check result.

Function
REQ-017 ethernet_rx_clk, ethernet_rx_dv and ethernet_rx SHALL pass through an identical SYNC_STAGES-deep flop chain; an "edge" is synced rx_clk=1 and previous synced value=0.
REQ-018 Data and dv SHALL be sampled only in the edge cycle, from the same synchroniser stage as the edge.
REQ-019 FSM states: UNDEFINED, HUNT, DATA, DROP.
REQ-020 UNDEFINED->HUNT when start=1; no other exit.
REQ-021 HUNT: on each edge with dv=1, shift a right-shifting 8-bit register with the new unit entering at the MSBs and count shifted bits, saturating at 8.
REQ-022 HUNT->DATA when the register equals 8'hD5 and the bit count is 8; the register, bit count and byte counter are cleared. An edge with dv=0 clears the bit count.
REQ-023 DATA: each edge with dv=1 shifts in one unit. After 8/PHY_W units, rx_byte is updated and byte_valid pulses on the next clk cycle; frame_len increments, saturating at all-ones.
REQ-024 frame_start SHALL pulse with the first byte_valid after the SFD only.
REQ-025 DATA, edge with dv=0: frame_end pulses on the next clk cycle, align_err=1 if the unit count is nonzero, crc_ok is presented, and the FSM returns to HUNT.
REQ-026 A dv that is still high when start is irrelevant (after UNDEFINED) and HUNT sees 8 bits not equal to 8'hD5 with a unit not 5/01 pattern SHALL NOT abort; hunting continues until dv falls.
REQ-027 DROP: entered from DATA when frame_len saturates; no byte_valid is issued. On an edge with dv=0, frame_end pulses with align_err=1, and the FSM goes to HUNT.
REQ-028 byte_valid and frame_end SHALL never be high in the same cycle.

Reset
REQ-029 On reset: state UNDEFINED, synchronisers 0, rx_byte 8'h00, frame_len 0, all strobes 0, align_err 0, crc_ok 0, CRC register all-ones.
REQ-030 Reset mid-frame SHALL discard the frame without emitting frame_end; start is required again.

Configuration
REQ-031 Macro ETHERNET_RX_FCS_EN defined: a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated per received unit in DATA and reset on SFD. crc_ok=1 when the residue equals 32'hC704DD7B at frame_end.
REQ-032 Macro ETHERNET_RX_FCS_EN undefined: no CRC logic; crc_ok SHALL be 1 whenever frame_end is high and 0 otherwise.

Structure
REQ-033 A shared package ethernet_pkg SHALL hold the FSM state encoding, SFD constant 8'hD5, CRC polynomial and residue constants.
REQ-034 The synchroniser SHALL be a sub-module ethernet_sync (parameter width and depth, reset to 0).

Verification
REQ-035 PHY_W=4, rx_clk period 8 clk: 15 nibbles 5, then nibble D, then bytes 01 02 03 -> byte_valid x3 with 01,02,03; frame_start with the 01 byte; frame_end with frame_len=3 and align_err=0.
REQ-036 PHY_W=2: preamble dibits 01 x31, then 11, then byte A5 -> one byte_valid with A5 and frame_len=1.
REQ-037 Frame ending after 3 nibbles of payload -> frame_end with frame_len=1 and align_err=1.
REQ-038 FCS_EN: 60-byte frame with a correct FCS -> crc_ok=1; the same frame with one payload bit flipped -> crc_ok=0.
REQ-039 Reset asserted mid-DATA, then start -> no frame_end; the next clean frame is received correctly.
REQ-040 start held 0 with valid frames on the line -> no strobes at all.
